mult_op_sequencer: RTL and testbench
====================================

# mult_op_sequencer

Control and staging block for the multiplier datapath's carry-save addition stage. It assembles two operands from the byte stream delivered by the UART/SPI receiver and drives them, registered and stable, into the 8-bit + 5-bit carry-save adder. After a fixed settling latency it captures the adder's 8-bit result. It then offers that result to the transmitter with a valid/ready handshake, guarding against overrun and stalled senders.

## Interface
Parameters:
- LAT, 1: cycles from operand launch to result capture; legal range 1..15.
- TIMEOUT, 255: cycles allowed between first and second operand byte before the pair is abandoned; legal range 1..65535.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- op_a  out  8  operand A to the adder (ia).
- op_b  out  5  operand B to the adder (ib).
- sum_in  in  8  adder result (ot), combinational from op_a/op_b.
- tx_data  out  8  captured result.
- tx_valid  out  1  result available.
- tx_ready  in  1  transmitter accepts tx_data.
- busy  out  1  high in any state other than IDLE.
- err_drop  out  1  one-cycle pulse on dropped byte or timeout.

## Operation
- Reset: state IDLE; op_a=0, op_b=0, tx_data=0, tx_valid=0, busy=0, err_drop=0; timeout and latency counters cleared. Reset mid-operation abandons any partial pair or pending result with no error pulse.
- IDLE: rx_valid -> latch rx_data into an internal A holding register (not op_a), go GOT_A, clear timeout counter.
- GOT_A: counter increments each cycle without rx_valid.
  - rx_valid: op_a <= A hold, op_b <= rx_data[4:0]; rx_data[7:5] ignored silently. Go EXEC.
  - Counter reaching TIMEOUT with no byte: pulse err_drop, return IDLE.
  - rx_valid in the same cycle as expiry: byte wins, pair accepted, no err_drop.
- EXEC: latency counter runs 1..LAT. In the LAT-th cycle, tx_data <= sum_in and tx_valid <= 1. Go HOLD.
- HOLD: tx_valid and tx_data held stable until tx_valid && tx_ready. On that edge, tx_valid <= 0 and the state returns to IDLE.
- op_a/op_b change only on pair acceptance. They hold their values through EXEC, HOLD and subsequent IDLE/GOT_A until the next pair.
- rx_valid in EXEC or HOLD, including the handshake cycle: byte discarded, err_drop pulses the following cycle; state unaffected.
- Arithmetic belongs entirely to the adder (sum_in = (op_a + op_b) mod 256). This block never modifies sum_in.

## Timing
- err_drop is registered: high exactly one cycle, the cycle after the causing event.
- Second byte strobed in cycle t: op_a/op_b valid from cycle t+1. sum_in is sampled at the end of cycle t+LAT. tx_valid is high from cycle t+LAT+1.
- Minimum pair-to-pair period: LAT+3 cycles when tx_ready is held high (accept, EXEC×LAT, HOLD handshake, IDLE).
- tx_ready high before tx_valid has no effect. The transfer occurs in the first cycle both are high.
- busy is registered from state: high from the cycle after the first byte until the cycle after the handshake.

## Test plan
- Basic pair, LAT=1, tx_ready=1: bytes 0x3C then 0x05 -> op_a=0x3C, op_b=0x05 the next cycle; tx_data=0x41, tx_valid one cycle, 2 cycles after the second strobe.
- Wrap and masking: bytes 0xFF then 0xFF -> op_b=0x1F, tx_data=0x1E; 0x10 then 0xE7 -> op_b=0x07, tx_data=0x17; no err_drop.
- Backpressure, LAT=3: pair 0x80/0x01, tx_ready low for 10 cycles -> tx_valid held with tx_data=0x81 throughout. A third byte sent meanwhile -> err_drop single pulse, result unchanged. Raise tx_ready -> one transfer, tx_valid low next cycle.
- Timeout, TIMEOUT=4: one byte 0x22, then silence -> err_drop pulse after expiry, busy low. Next pair 0x01/0x02 -> tx_data=0x03 (0x22 is not reused).
- Boundary, TIMEOUT=4: second byte strobed exactly in the expiry cycle -> pair accepted, no err_drop, result produced.
- Reset mid-HOLD: assert rst asynchronously while tx_valid=1 -> all outputs 0 immediately, no err_drop. Subsequent pair 0x0A/0x0B -> tx_data=0x15.

Source files
------------

// File: rtl/mult_op_sequencer_if.sv
// Byte-stream, adder-operand and result-handshake signals of the multiplier carry-save stage sequencer.
// The sequencer connects through the slave modport. Its environment (receiver, adder, transmitter) uses the master modport.
interface mult_op_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] op_a;
    logic [4:0] op_b;
    logic [7:0] sum_in;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err_drop;

    modport slave (
        input  rx_data, rx_valid, sum_in, tx_ready,
        output op_a, op_b, tx_data, tx_valid, busy, err_drop
    );

    modport master (
        output rx_data, rx_valid, sum_in, tx_ready,
        input  op_a, op_b, tx_data, tx_valid, busy, err_drop
    );
endinterface

// File: rtl/mult_op_sequencer.sv
// Assembles an operand pair from received bytes and drives it into the carry-save adder.
// Captures the adder result after LAT cycles and offers it on a valid/ready handshake.
module mult_op_sequencer #(
    parameter int LAT     = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_op_sequencer_if.slave    bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GOT_A = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  LAT_LAST = 4'(LAT);

    logic [1:0]  state_q,    state_d;
    logic [7:0]  a_hold_q,   a_hold_d;
    logic [7:0]  op_a_q,     op_a_d;
    logic [4:0]  op_b_q,     op_b_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        err_q,      err_d;
    logic [15:0] to_cnt_q,   to_cnt_d;
    logic [3:0]  lat_cnt_q,  lat_cnt_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        a_hold_d   = a_hold_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        err_d      = 1'b0;
        to_cnt_d   = to_cnt_q;
        lat_cnt_d  = lat_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    a_hold_d = bus.rx_data;
                    to_cnt_d = '0;
                    state_d  = GOT_A;
                end
            end
            GOT_A: begin
                // A byte arriving in the expiry cycle still completes the pair.
                if (bus.rx_valid) begin
                    op_a_d    = a_hold_q;
                    op_b_d    = bus.rx_data[4:0];
                    lat_cnt_d = 4'd1;
                    state_d   = EXEC;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            EXEC: begin
                err_d = bus.rx_valid;
                if (lat_cnt_q == LAT_LAST) begin
                    tx_data_d  = bus.sum_in;
                    tx_valid_d = 1'b1;
                    state_d    = HOLD;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            HOLD: begin
                err_d = bus.rx_valid;
                if (tx_valid_q && bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_hold_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            to_cnt_q   <= '0;
            lat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            a_hold_q   <= a_hold_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            err_q      <= err_d;
            to_cnt_q   <= to_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.err_drop = err_q;

endmodule

// File: tb/tb_mult_op_sequencer.sv
// Drives identical byte streams into a LAT=1 and a LAT=3 sequencer and compares every output each cycle.
// The reference is a transaction model keyed on cycle stamps.
module tb_mult_op_sequencer;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int TO    = 4;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;

    int checks;
    int errors;
    int cyc;

    mult_op_sequencer_if if_a ();
    mult_op_sequencer_if if_b ();

    assign if_a.rx_data  = rx_data;
    assign if_a.rx_valid = rx_valid;
    assign if_a.tx_ready = tx_ready;
    assign if_a.sum_in   = if_a.op_a + {3'b000, if_a.op_b};
    assign if_b.rx_data  = rx_data;
    assign if_b.rx_valid = rx_valid;
    assign if_b.tx_ready = tx_ready;
    assign if_b.sum_in   = if_b.op_a + {3'b000, if_b.op_b};

    mult_op_sequencer #(.LAT(LAT_A), .TIMEOUT(TO)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    mult_op_sequencer #(.LAT(LAT_B), .TIMEOUT(TO)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction view: a pending first byte with its arrival cycle, a computation due at a given
    // cycle, or a result waiting for the transmitter.
    typedef struct {
        bit         has_a;
        logic [7:0] a_val;
        int         a_cyc;
        bit         running;
        int         cap_cyc;
        bit         holding;
        logic [7:0] op_a;
        logic [4:0] op_b;
        logic [7:0] tx_data;
        bit         tx_valid;
        bit         err;
    } model_t;

    model_t m_a, m_b;

    function automatic model_t model_reset();
        model_t r;
        r.has_a = 0; r.a_val = '0; r.a_cyc = 0;
        r.running = 0; r.cap_cyc = 0; r.holding = 0;
        r.op_a = '0; r.op_b = '0; r.tx_data = '0; r.tx_valid = 0; r.err = 0;
        return r;
    endfunction

    function automatic model_t step(model_t m, int lat, int to, int c,
                                    logic rv, logic [7:0] rd, logic tr);
        model_t n = m;
        n.err = 0;
        if (m.holding) begin
            if (tr) begin
                n.tx_valid = 0;
                n.holding  = 0;
            end
            if (rv) n.err = 1;
        end else if (m.running) begin
            if (rv) n.err = 1;
            if (c == m.cap_cyc) begin
                n.tx_data  = m.op_a + {3'b000, m.op_b};
                n.tx_valid = 1;
                n.running  = 0;
                n.holding  = 1;
            end
        end else if (m.has_a) begin
            if (rv) begin
                n.op_a    = m.a_val;
                n.op_b    = rd[4:0];
                n.has_a   = 0;
                n.running = 1;
                n.cap_cyc = c + lat;
            end else if (c - m.a_cyc >= to) begin
                n.has_a = 0;
                n.err   = 1;
            end
        end else if (rv) begin
            n.has_a = 1;
            n.a_val = rd;
            n.a_cyc = c;
        end
        return n;
    endfunction

    task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        compare("a.op_a",     if_a.op_a,               m_a.op_a);
        compare("a.op_b",     {3'b000, if_a.op_b},     {3'b000, m_a.op_b});
        compare("a.tx_data",  if_a.tx_data,            m_a.tx_data);
        compare("a.tx_valid", {7'd0, if_a.tx_valid},   {7'd0, m_a.tx_valid});
        compare("a.busy",     {7'd0, if_a.busy},       {7'd0, (m_a.has_a | m_a.running | m_a.holding)});
        compare("a.err_drop", {7'd0, if_a.err_drop},   {7'd0, m_a.err});
        compare("b.op_a",     if_b.op_a,               m_b.op_a);
        compare("b.op_b",     {3'b000, if_b.op_b},     {3'b000, m_b.op_b});
        compare("b.tx_data",  if_b.tx_data,            m_b.tx_data);
        compare("b.tx_valid", {7'd0, if_b.tx_valid},   {7'd0, m_b.tx_valid});
        compare("b.busy",     {7'd0, if_b.busy},       {7'd0, (m_b.has_a | m_b.running | m_b.holding)});
        compare("b.err_drop", {7'd0, if_b.err_drop},   {7'd0, m_b.err});
    endtask

    // One clock cycle: drive inputs just after the edge, check at the falling edge, advance the model.
    task automatic tick(input logic rv, input logic [7:0] rd, input logic tr);
        rx_valid = rv;
        rx_data  = rd;
        tx_ready = tr;
        @(negedge clk);
        compare_all();
        m_a = step(m_a, LAT_A, TO, cyc, rv, rd, tr);
        m_b = step(m_b, LAT_B, TO, cyc, rv, rd, tr);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] b, input logic tr);
        tick(1'b1, b, tr);
    endtask

    task automatic idle(input int n, input logic tr);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, tr);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        rst      = 1'b1;
        m_a      = model_reset();
        m_b      = model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic pair: 0x3C + 0x05
        send(8'h3C, 1'b1); send(8'h05, 1'b1); idle(6, 1'b1);

        // Wrap and operand B masking
        send(8'hFF, 1'b1); send(8'hFF, 1'b1); idle(6, 1'b1);
        send(8'h10, 1'b1); send(8'hE7, 1'b1); idle(6, 1'b1);

        // Backpressure with a stray byte while the result is held
        send(8'h80, 1'b0); send(8'h01, 1'b0); idle(3, 1'b0);
        send(8'h55, 1'b0); idle(6, 1'b0); idle(6, 1'b1);

        // Timeout then a fresh pair
        send(8'h22, 1'b1); idle(8, 1'b1);
        send(8'h01, 1'b1); send(8'h02, 1'b1); idle(6, 1'b1);

        // Second byte exactly in the expiry cycle, then one cycle too late
        send(8'h33, 1'b1); idle(TO - 1, 1'b1); send(8'h04, 1'b1); idle(6, 1'b1);
        send(8'h44, 1'b1); idle(TO, 1'b1); send(8'h05, 1'b1); send(8'h06, 1'b1); idle(6, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic       rv;
            logic       tr;
            logic [7:0] rd;
            rv = ($urandom_range(0, 2) == 0);
            tr = ($urandom_range(0, 1) == 1);
            rd = 8'($urandom);
            tick(rv, rd, tr);
        end
        idle(12, 1'b1);

        // Asynchronous reset while a result is held
        send(8'h10, 1'b0); send(8'h20, 1'b0); idle(5, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        m_a = model_reset();
        m_b = model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        send(8'h0A, 1'b1); send(8'h0B, 1'b1); idle(6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
